// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

    // Run/pause/done state machine encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Default pacing: one count tick per second at 50 MHz.
    localparam int DEF_TICK_DIV = 50000000;
    // Default minute value at which counting stops on its own.
    localparam int DEF_MAX_MIN  = 59;
    // Width of the seconds/minutes display fields.
    localparam int DISP_W       = 8;

    // Button index within the edge-detector bank.
    localparam int BTN_SS  = 0;
    localparam int BTN_LAP = 1;
    localparam int BTN_CLR = 2;
    localparam int BTN_N   = 3;

    // A clear press is only honoured when the counter is not running.
    function automatic logic clr_allowed(input state_t s);
        return (s != ST_RUN);
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Single-bit rising-edge detector for a pre-debounced button level.
// The history register resets to 1 so a button held through reset
// never produces a press when reset releases.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    logic r_hist;

    // Track the previous button level; reset as "already pressed".
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 1'b1;
        end else begin
            r_hist <= i_btn;
        end
    end

    assign o_press = i_btn & ~r_hist;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: turns start/stop, lap and clear buttons into the
// counter's count-enable and clear strobes, paces counting with a
// prescaler, and holds a frozen lap value for the display.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int DIV_W    = 26,
    parameter int MAX_MIN  = DEF_MAX_MIN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_ss,
    input  logic              btn_lap,
    input  logic              btn_clr,
    input  logic [DISP_W-1:0] sec_in,
    input  logic [DISP_W-1:0] min_in,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic [DISP_W-1:0] disp_sec,
    output logic [DISP_W-1:0] disp_min,
    output logic              lap_active,
    output logic              running,
    output logic              done
);

    // Last prescaler value before wrap, and the auto-stop minute value,
    // sized to the signals they are compared against.
    localparam logic [DIV_W-1:0]  TICK_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [DISP_W-1:0] MIN_LIMIT = DISP_W'(MAX_MIN);

    // ---------------------------------------------------------------
    // Button edge detection
    // ---------------------------------------------------------------
    logic [BTN_N-1:0] w_btn_vec;
    logic [BTN_N-1:0] w_press_vec;
    logic             w_press_ss;
    logic             w_press_lap;
    logic             w_press_clr;

    assign w_btn_vec[BTN_SS]  = btn_ss;
    assign w_btn_vec[BTN_LAP] = btn_lap;
    assign w_btn_vec[BTN_CLR] = btn_clr;

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
        btn_edge u_edge (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (w_btn_vec[gi]),
            .o_press (w_press_vec[gi])
        );
    end

    assign w_press_ss  = w_press_vec[BTN_SS];
    assign w_press_lap = w_press_vec[BTN_LAP];
    assign w_press_clr = w_press_vec[BTN_CLR];

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    state_t             r_state;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_cnt_en;
    logic               r_cnt_clr;
    logic               r_lap_active;
    logic [DISP_W-1:0]  r_hold_sec;
    logic [DISP_W-1:0]  r_hold_min;

    // ---------------------------------------------------------------
    // Combinational decode
    // ---------------------------------------------------------------
    state_t w_state_next;
    logic   w_clr_accept;
    logic   w_tick;
    logic   w_lap_next;
    logic   w_lap_capture;

    // A tick is the last cycle of a prescaler period while running. It is
    // raised even in a cycle where the state is about to leave RUN, so
    // the completed period is still counted.
    assign w_tick = (r_state == ST_RUN) && (r_div_cnt == TICK_LAST);

    // Next-state selection and clear acceptance.
    always_comb begin
        w_state_next = r_state;
        w_clr_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Clear takes precedence over start when both are pressed
                // together, matching the PAUSE-state ordering.
                if (w_press_clr) begin
                    w_clr_accept = 1'b1;
                end else if (w_press_ss) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                // Reaching the minute limit beats a simultaneous pause.
                if (min_in >= MIN_LIMIT) begin
                    w_state_next = ST_DONE;
                end else if (w_press_ss) begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_press_clr) begin
                    w_clr_accept = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_press_ss) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_press_clr) begin
                    w_clr_accept = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        // Guard against any future edit letting a clear through in RUN.
        if (!clr_allowed(r_state)) begin
            w_clr_accept = 1'b0;
        end
    end

    // Lap toggle/clear decision and hold-register capture enable.
    always_comb begin
        w_lap_next    = r_lap_active;
        w_lap_capture = 1'b0;
        if (w_clr_accept) begin
            // An accepted clear always unfreezes the display, even when a
            // lap press lands in the same cycle.
            w_lap_next = 1'b0;
        end else if (w_press_lap) begin
            case (r_state)
                ST_RUN, ST_PAUSE: begin
                    w_lap_next    = ~r_lap_active;
                    w_lap_capture = ~r_lap_active;
                end
                ST_DONE: begin
                    w_lap_next = 1'b0;
                end
                default: begin
                    w_lap_next = r_lap_active;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Sequential logic
    // ---------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Prescaler: advances only in RUN and holds otherwise, so a pause
    // resumes mid-period; a clear restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
        end else if (w_clr_accept) begin
            r_div_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            if (r_div_cnt == TICK_LAST) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    // Counter strobes: registered tick and clear pulse. Clear is held
    // high throughout reset so the counter starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_en  <= 1'b0;
            r_cnt_clr <= 1'b1;
        end else begin
            r_cnt_en  <= w_tick;
            r_cnt_clr <= w_clr_accept;
        end
    end

    // Lap flag and hold registers; the live value is captured on the
    // same edge that freezes the display.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap_active <= 1'b0;
            r_hold_sec   <= '0;
            r_hold_min   <= '0;
        end else begin
            r_lap_active <= w_lap_next;
            if (w_lap_capture) begin
                r_hold_sec <= sec_in;
                r_hold_min <= min_in;
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign cnt_en     = r_cnt_en;
    assign cnt_clr    = r_cnt_clr;
    assign lap_active = r_lap_active;
    assign running    = (r_state == ST_RUN);
    assign done       = (r_state == ST_DONE);
    assign disp_sec   = r_lap_active ? r_hold_sec : sec_in;
    assign disp_min   = r_lap_active ? r_hold_min : min_in;

endmodule
